// File: rtl/mips_avalon_arbiter_if.sv
// One Avalon-MM link (address/control/data plus waitrequest/readdata).
// The arbiter uses three of these: two toward the CPU masters, one toward the RAM.
interface mips_avalon_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_avalon_arbiter.sv
// Two-master (M0 ifetch, M1 data) to one-slave Avalon-MM arbiter, fixed M1 priority with M0 starvation guard.
// Define MIPS_ARB_ROUND_ROBIN_EN to replace fixed priority with alternating round-robin on contention.
module mips_avalon_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    mips_avalon_arbiter_if.slave  m0,
    mips_avalon_arbiter_if.slave  m1,
    mips_avalon_arbiter_if.master s
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic m0_req;
    logic m1_req;
    logic pick0;
    logic enter0;
    logic enter1;

    logic [ADDR_WIDTH-1:0]   addr_mux;
    logic [DATA_WIDTH-1:0]   wdata_mux;
    logic [DATA_WIDTH/8-1:0] be_mux;
    logic                    read_mux;
    logic                    write_mux;
    logic                    m0_wait;
    logic                    m1_wait;

    assign m0_req = m0.read | m0.write;
    assign m1_req = m1.read | m1.write;

    assign enter0 = (state == IDLE) && (next_state == GRANT0);
    assign enter1 = (state == IDLE) && (next_state == GRANT1);

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    // last_grant: 0 = M0 was granted last, 1 = M1; the other master wins a tie.
    logic last_grant;

    assign pick0 = m0_req & (~m1_req | last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b0;
        end else if (enter0) begin
            last_grant <= 1'b0;
        end else if (enter1) begin
            last_grant <= 1'b1;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign pick0 = m0_req & (~m1_req | (starve_cnt >= STARVE_LIM));

    // Counts M1 grants taken while M0 was already waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (enter0) begin
            starve_cnt <= 4'd0;
        end else if (enter1) begin
            starve_cnt <= m0_req ? sat_inc(starve_cnt) : 4'd0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A grant ends on completion or when the owner drops its request (abort).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (pick0) begin
                    next_state = GRANT0;
                end else if (m1_req) begin
                    next_state = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_req || !s.waitrequest) begin
                    next_state = IDLE;
                end
            end
            GRANT1: begin
                if (!m1_req || !s.waitrequest) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Non-owners stall only while they are requesting.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        be_mux    = '0;
        read_mux  = 1'b0;
        write_mux = 1'b0;
        m0_wait   = m0_req;
        m1_wait   = m1_req;
        unique case (state)
            GRANT0: begin
                addr_mux  = m0.address;
                wdata_mux = m0.writedata;
                be_mux    = m0.byteenable;
                read_mux  = m0.read;
                write_mux = m0.write;
                m0_wait   = s.waitrequest;
            end
            GRANT1: begin
                addr_mux  = m1.address;
                wdata_mux = m1.writedata;
                be_mux    = m1.byteenable;
                read_mux  = m1.read;
                write_mux = m1.write;
                m1_wait   = s.waitrequest;
            end
            default: begin
            end
        endcase
    end

    assign s.address    = addr_mux;
    assign s.writedata  = wdata_mux;
    assign s.byteenable = be_mux;
    assign s.read       = read_mux;
    assign s.write      = write_mux;

    assign m0.waitrequest = m0_wait;
    assign m1.waitrequest = m1_wait;
    assign m0.readdata    = s.readdata;
    assign m1.readdata    = s.readdata;
endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench for mips_avalon_arbiter with a small behavioural RAM (read delay 2, base 0xBFC00000).
module tb_mips_avalon_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic force_wait;

    int n_chk  = 0;
    int n_fail = 0;

    mips_avalon_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
    mips_avalon_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
    mips_avalon_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

    mips_avalon_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .m0   (m0_bus),
        .m1   (m1_bus),
        .s    (s_bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: reads stall two cycles, writes complete at once.
    logic [31:0] mem [0:3];
    logic [1:0]  rd_cnt = 2'd0;
    logic        model_wait;

    assign model_wait        = s_bus.read && (rd_cnt < 2'd2);
    assign s_bus.waitrequest = force_wait | model_wait;
    assign s_bus.readdata    = mem[s_bus.address[3:2]];

    always @(posedge clk) begin
        if (!s_bus.read || !s_bus.waitrequest) rd_cnt <= 2'd0;
        else if (rd_cnt < 2'd2) rd_cnt <= rd_cnt + 2'd1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= 32'h11111111;
            mem[1] <= 32'h22222222;
            mem[2] <= 32'h33333333;
            mem[3] <= 32'h44444444;
        end else if (s_bus.write && !s_bus.waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (s_bus.byteenable[b])
                    mem[s_bus.address[3:2]][8*b +: 8] <= s_bus.writedata[8*b +: 8];
        end
    end

    // Completion log: 0 = M0 served, 1 = M1 served.
    bit grant_log[$];
    int wr_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((m0_bus.read || m0_bus.write) && !m0_bus.waitrequest) grant_log.push_back(1'b0);
            if ((m1_bus.read || m1_bus.write) && !m1_bus.waitrequest) grant_log.push_back(1'b1);
            if (s_bus.write && !s_bus.waitrequest) wr_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic clear_masters();
        m0_bus.address = '0; m0_bus.read = 1'b0; m0_bus.write = 1'b0;
        m0_bus.writedata = '0; m0_bus.byteenable = 4'hF;
        m1_bus.address = '0; m1_bus.read = 1'b0; m1_bus.write = 1'b0;
        m1_bus.writedata = '0; m1_bus.byteenable = 4'hF;
    endtask

    task automatic do_read(input bit sel, input logic [31:0] addr,
                           output logic [31:0] data, output int cyc);
        cyc  = 0;
        data = '0;
        @(posedge clk); #1;
        if (sel) begin m1_bus.address = addr; m1_bus.read = 1'b1; end
        else     begin m0_bus.address = addr; m0_bus.read = 1'b1; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cyc++;
            if (sel ? !m1_bus.waitrequest : !m0_bus.waitrequest) begin
                data = sel ? m1_bus.readdata : m0_bus.readdata;
                break;
            end
        end
        @(posedge clk); #1;
        if (sel) m1_bus.read = 1'b0; else m0_bus.read = 1'b0;
    endtask

    task automatic do_write(input bit sel, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, output int cyc);
        cyc = 0;
        @(posedge clk); #1;
        if (sel) begin
            m1_bus.address = addr; m1_bus.writedata = wd; m1_bus.byteenable = be; m1_bus.write = 1'b1;
        end else begin
            m0_bus.address = addr; m0_bus.writedata = wd; m0_bus.byteenable = be; m0_bus.write = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cyc++;
            if (sel ? !m1_bus.waitrequest : !m0_bus.waitrequest) break;
        end
        @(posedge clk); #1;
        if (sel) begin m1_bus.write = 1'b0; m1_bus.byteenable = 4'hF; end
        else     begin m0_bus.write = 1'b0; m0_bus.byteenable = 4'hF; end
    endtask

    initial begin
        logic [31:0] rdata;
        int          cyc;
        int          wr_base;
        bit          exp_grant;

        rst_n      = 1'b0;
        force_wait = 1'b0;
        clear_masters();

        // Reset with M1 already requesting
        m1_bus.address = 32'hBFC00004;
        m1_bus.read    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_read", s_bus.read, 1'b0);
        chk("rst_s_addr", s_bus.address, 32'h0);
        chk("rst_m1_wait", m1_bus.waitrequest, 1'b1);
        chk("rst_m0_wait", m0_bus.waitrequest, 1'b0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("g1_s_read", s_bus.read, 1'b1);
        chk("g1_s_addr", s_bus.address, 32'hBFC00004);

        // Async reset in the middle of GRANT1
        #2 rst_n = 1'b0;
        #1;
        chk("async_s_read", s_bus.read, 1'b0);
        chk("async_s_addr", s_bus.address, 32'h0);
        m1_bus.read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_m1_wait", m1_bus.waitrequest, 1'b0);

        // Solo M0 read: 1 IDLE + 2 stalled + 1 completing cycle
        do_read(1'b0, 32'hBFC00000, rdata, cyc);
        chk("m0_read_data", rdata, 32'h11111111);
        chk("m0_read_cycles", cyc, 32'd4);

        // Continuous contention
        grant_log.delete();
        @(posedge clk); #1;
        m0_bus.address = 32'hBFC00000; m0_bus.read = 1'b1;
        m1_bus.address = 32'hBFC00004; m1_bus.read = 1'b1;
        for (int i = 0; i < 400 && grant_log.size() < 10; i++) @(negedge clk);
        @(posedge clk); #1;
        m0_bus.read = 1'b0;
        m1_bus.read = 1'b0;
        chk("contention_count", grant_log.size(), 32'd10);
        for (int k = 0; k < 10; k++) begin
`ifdef MIPS_ARB_ROUND_ROBIN_EN
            exp_grant = (k % 2 == 0);
`else
            exp_grant = (k % 5 != 4);
`endif
            chk($sformatf("grant%0d", k), (k < grant_log.size()) ? {31'd0, grant_log[k]} : 32'hFFFFFFFF,
                {31'd0, exp_grant});
        end

        // Byte-lane write by M1, read back by M0
        wr_base = wr_seen;
        do_write(1'b1, 32'hBFC00008, 32'hDEADBEEF, 4'b0110, cyc);
        chk("m1_write_cycles", cyc, 32'd2);
        do_read(1'b0, 32'hBFC00008, rdata, cyc);
        chk("m0_readback", rdata, 32'h33ADBE33);
        chk("write_once", wr_seen - wr_base, 32'd1);

        // M0 abandons its read while the slave stalls; waiting M1 follows
        force_wait = 1'b1;
        @(posedge clk); #1;
        m0_bus.address = 32'hBFC0000C; m0_bus.read = 1'b1;
        @(negedge clk);
        chk("abort_idle_m0_wait", m0_bus.waitrequest, 1'b1);
        @(negedge clk);
        chk("abort_g0_addr", s_bus.address, 32'hBFC0000C);
        chk("abort_g0_read", s_bus.read, 1'b1);
        @(posedge clk); #1;
        m0_bus.read    = 1'b0;
        m1_bus.address = 32'hBFC00004;
        m1_bus.read    = 1'b1;
        @(negedge clk);
        chk("abort_read_drop", s_bus.read, 1'b0);
        chk("abort_m1_wait", m1_bus.waitrequest, 1'b1);
        @(negedge clk);
        chk("abort_idle_addr", s_bus.address, 32'h0);
        chk("abort_idle_m1_wait", m1_bus.waitrequest, 1'b1);
        @(negedge clk);
        chk("abort_g1_addr", s_bus.address, 32'hBFC00004);
        chk("abort_g1_read", s_bus.read, 1'b1);
        force_wait = 1'b0;
        rdata = '0;
        cyc   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (!m1_bus.waitrequest) begin
                rdata = m1_bus.readdata;
                break;
            end
        end
        @(posedge clk); #1;
        m1_bus.read = 1'b0;
        chk("abort_m1_data", rdata, 32'h22222222);
        chk("abort_m1_cycles", cyc, 32'd2);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
